// File: rtl/fp_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fp_pkg : state/class encodings, flag masks and constant-word builders.
// Rev 1.0
// -----------------------------------------------------------------------------
package fp_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UNPACK  = 3'd1,
    S_SPECIAL = 3'd2,
    S_ALIGN   = 3'd3,
    S_ADD     = 3'd4,
    S_NORM    = 3'd5,
    S_ROUND   = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_t;

  localparam int FLG_INX = 0;
  localparam int FLG_UNF = 1;
  localparam int FLG_OVF = 2;
  localparam int FLG_INV = 3;

  localparam logic [3:0] FLAG_INX = 4'b0001;
  localparam logic [3:0] FLAG_UNF = 4'b0010;
  localparam logic [3:0] FLAG_OVF = 4'b0100;
  localparam logic [3:0] FLAG_INV = 4'b1000;

  // Words are built in a 64-bit container and sized down by the caller.
  function automatic logic [63:0] fp_inf(input logic sign, input int exp_w, input int man_w);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < exp_w; i++) w[man_w+i] = 1'b1;
    w[man_w+exp_w] = sign;
    return w;
  endfunction

  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    logic [63:0] w;
    w = fp_inf(1'b0, exp_w, man_w);
    w[man_w-1] = 1'b1;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_unpack_classify.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fp_unpack_classify : splits a packed word into sign/exponent/mantissa and class.
// Rev 1.0
// -----------------------------------------------------------------------------
module fp_unpack_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] i_word,
  output logic                 o_sign,
  output logic [EXP_W-1:0]     o_exp,
  output logic [MAN_W:0]       o_man,
  output cls_t                 o_cls
);

  logic w_exp_zero;
  logic w_exp_ones;
  logic w_frac_nz;

  assign o_sign     = i_word[EXP_W+MAN_W];
  assign o_exp      = i_word[EXP_W+MAN_W-1:MAN_W];
  assign w_exp_zero = (o_exp == '0);
  assign w_exp_ones = &o_exp;
  assign w_frac_nz  = |i_word[MAN_W-1:0];

  // Subnormals collapse to a signed zero here, so no later stage sees them.
  assign o_man = w_exp_zero ? '0 : {1'b1, i_word[MAN_W-1:0]};

  always_comb begin
    o_cls = CLS_NORM;
    if (w_exp_ones)      o_cls = w_frac_nz ? CLS_NAN : CLS_INF;
    else if (w_exp_zero) o_cls = CLS_ZERO;
  end

endmodule
`default_nettype wire

// File: rtl/fp_add_sub_seq.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fp_add_sub_seq : multi-cycle IEEE-754-style add/sub, RNE, flush-to-zero, flags.
// Rev 1.0
// -----------------------------------------------------------------------------
module fp_add_sub_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [EXP_W+MAN_W:0] result,
  output logic [3:0]           flags
);

  localparam int c_w  = 1 + EXP_W + MAN_W;
  localparam int c_mw = MAN_W + 4;
  localparam int c_xw = EXP_W + 2;
  localparam logic [EXP_W-1:0]        c_d_max   = EXP_W'(MAN_W + 3);
  localparam logic [EXP_W-1:0]        c_d_one   = EXP_W'(1);
  localparam logic signed [c_xw-1:0]  c_exp_one = c_xw'(1);
  localparam logic signed [c_xw-1:0]  c_exp_max = c_xw'((1 << EXP_W) - 1);

  state_t r_state, w_next;

  logic [c_w-1:0]          r_a, r_b, r_result;
  logic [3:0]              r_flags;
  logic                    r_eff_sub, r_sign;
  logic signed [c_xw-1:0]  r_exp;
  logic [EXP_W-1:0]        r_d;
  logic [c_mw-1:0]         r_mbig, r_msml;

  logic             w_sa, w_sb;
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W:0]   w_ma, w_mb;
  cls_t             w_ca, w_cb;

  fp_unpack_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .i_word(r_a), .o_sign(w_sa), .o_exp(w_ea), .o_man(w_ma), .o_cls(w_ca)
  );
  fp_unpack_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .i_word(r_b), .o_sign(w_sb), .o_exp(w_eb), .o_man(w_mb), .o_cls(w_cb)
  );

  logic w_a_ge, w_special, w_nan_out;
  assign w_a_ge    = (w_ea > w_eb) || ((w_ea == w_eb) && (w_ma >= w_mb));
  assign w_special = (w_ca != CLS_NORM) || (w_cb != CLS_NORM);
  assign w_nan_out = (w_ca == CLS_NAN) || (w_cb == CLS_NAN) ||
                     ((w_ca == CLS_INF) && (w_cb == CLS_INF) && (w_sa != w_sb));

  // |big| >= |small| is guaranteed by the swap, so the difference never borrows.
  logic [c_mw:0] w_sum;
  assign w_sum = r_eff_sub ? ({1'b0, r_mbig} - {1'b0, r_msml})
                           : ({1'b0, r_mbig} + {1'b0, r_msml});

  logic [MAN_W:0]         w_keep;
  logic                   w_up;
  logic [MAN_W+1:0]       w_rnd;
  logic [MAN_W-1:0]       w_rfrac;
  logic signed [c_xw-1:0] w_rexp;
  assign w_keep  = r_mbig[c_mw-1:3];
  assign w_up    = r_mbig[2] & (r_mbig[1] | r_mbig[0] | w_keep[0]);
  assign w_rnd   = {1'b0, w_keep} + {{(MAN_W+1){1'b0}}, w_up};
  assign w_rfrac = w_rnd[MAN_W+1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
  assign w_rexp  = r_exp + (w_rnd[MAN_W+1] ? c_exp_one : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_UNPACK;
      S_UNPACK:  w_next = w_special ? S_SPECIAL : S_ALIGN;
      S_SPECIAL: w_next = S_DONE;
      S_ALIGN:   if ((r_d <= c_d_one) || (r_d > c_d_max)) w_next = S_ADD;
      S_ADD:     w_next = S_NORM;
      S_NORM: begin
        if (r_mbig == '0)                              w_next = S_DONE;
        else if (r_mbig[c_mw-1] || (r_exp == c_exp_one)) w_next = S_ROUND;
      end
      S_ROUND:   w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_flags   <= '0;
      r_eff_sub <= 1'b0;
      r_sign    <= 1'b0;
      r_exp     <= '0;
      r_d       <= '0;
      r_mbig    <= '0;
      r_msml    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_a <= a;
          r_b <= {b[c_w-1] ^ sub, b[c_w-2:0]};
        end
        S_UNPACK: begin
          r_eff_sub <= w_sa ^ w_sb;
          if (w_a_ge) begin
            r_sign <= w_sa;
            r_exp  <= $signed({2'b00, w_ea});
            r_mbig <= {w_ma, 3'b000};
            r_msml <= {w_mb, 3'b000};
            r_d    <= w_ea - w_eb;
          end else begin
            r_sign <= w_sb;
            r_exp  <= $signed({2'b00, w_eb});
            r_mbig <= {w_mb, 3'b000};
            r_msml <= {w_ma, 3'b000};
            r_d    <= w_eb - w_ea;
          end
        end
        S_SPECIAL: begin
          r_flags <= '0;
          if (w_nan_out) begin
            r_result <= c_w'(fp_qnan(EXP_W, MAN_W));
            r_flags  <= FLAG_INV;
          end else if (w_ca == CLS_INF)                       r_result <= r_a;
          else if (w_cb == CLS_INF)                           r_result <= r_b;
          else if ((w_ca == CLS_ZERO) && (w_cb == CLS_ZERO))  r_result <= {w_sa & w_sb, {(c_w-1){1'b0}}};
          else if (w_ca == CLS_ZERO)                          r_result <= r_b;
          else                                                r_result <= r_a;
        end
        S_ALIGN: begin
          if (r_d > c_d_max) begin
            r_msml <= {{(c_mw-1){1'b0}}, |r_msml};
            r_d    <= '0;
          end else if (r_d != '0) begin
            r_msml <= {1'b0, r_msml[c_mw-1:2], r_msml[1] | r_msml[0]};
            r_d    <= r_d - c_d_one;
          end
        end
        S_ADD: begin
          if (w_sum[c_mw]) begin
            r_mbig <= {w_sum[c_mw:2], w_sum[1] | w_sum[0]};
            r_exp  <= r_exp + c_exp_one;
          end else begin
            r_mbig <= w_sum[c_mw-1:0];
          end
        end
        S_NORM: begin
          if (r_mbig == '0) begin
            r_result <= '0;
            r_flags  <= '0;
          end else if (!r_mbig[c_mw-1] && (r_exp != c_exp_one)) begin
            r_mbig <= {r_mbig[c_mw-2:0], 1'b0};
            r_exp  <= r_exp - c_exp_one;
          end
        end
        S_ROUND: begin
          // A hidden bit still clear here means the value sits below min normal.
          if (!r_mbig[c_mw-1]) begin
            r_result <= {r_sign, {(c_w-1){1'b0}}};
            r_flags  <= FLAG_UNF | FLAG_INX;
          end else if (w_rexp >= c_exp_max) begin
            r_result <= c_w'(fp_inf(r_sign, EXP_W, MAN_W));
            r_flags  <= FLAG_OVF | FLAG_INX;
          end else begin
            r_result <= {r_sign, w_rexp[EXP_W-1:0], w_rfrac};
            r_flags  <= {3'b000, |r_mbig[2:0]};
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign flags  = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_sub_seq.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_fp_add_sub_seq : scoreboard bench for single- and half-width adder instances.
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_fp_add_sub_seq;

  localparam int LIM_SP = 2*23 + 12;
  localparam int LIM_HP = 2*10 + 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s_start, s_sub, s_busy, s_done;
  logic [31:0] s_a, s_b, s_result;
  logic [3:0]  s_flags;
  logic        h_start, h_sub, h_busy, h_done;
  logic [15:0] h_a, h_b, h_result;
  logic [3:0]  h_flags;

  fp_add_sub_seq #(.EXP_W(8), .MAN_W(23)) u_sp (
    .clk(clk), .rst(rst), .start(s_start), .sub(s_sub), .a(s_a), .b(s_b),
    .busy(s_busy), .done(s_done), .result(s_result), .flags(s_flags)
  );

  fp_add_sub_seq #(.EXP_W(5), .MAN_W(10)) u_hp (
    .clk(clk), .rst(rst), .start(h_start), .sub(h_sub), .a(h_a), .b(h_b),
    .busy(h_busy), .done(h_done), .result(h_result), .flags(h_flags)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_done_sp = 0;
  logic [35:0] q_sp[$];
  string       q_tag_sp[$];
  logic [19:0] q_hp[$];
  logic [35:0] m_sp_e;
  string       m_sp_tag;
  logic [19:0] m_hp_e;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard monitors: every done pops one expectation.
  initial forever begin
    @(negedge clk);
    if (s_done === 1'b1) begin
      n_done_sp++;
      if (q_sp.size() == 0) check("sp_unexpected_done", 64'(s_done), 64'd0);
      else begin
        m_sp_e   = q_sp.pop_front();
        m_sp_tag = q_tag_sp.pop_front();
        check({m_sp_tag, "_result"}, 64'(s_result), 64'(m_sp_e[35:4]));
        check({m_sp_tag, "_flags"},  64'(s_flags),  64'(m_sp_e[3:0]));
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (h_done === 1'b1) begin
      if (q_hp.size() == 0) check("hp_unexpected_done", 64'(h_done), 64'd0);
      else begin
        m_hp_e = q_hp.pop_front();
        check("hp_result", 64'(h_result), 64'(m_hp_e[19:4]));
        check("hp_flags",  64'(h_flags),  64'(m_hp_e[3:0]));
      end
    end
  end

  // exact_lat = 0 checks only the worst-case bound.
  task automatic run_sp(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input logic isub, input logic [31:0] er, input logic [3:0] ef,
                        input int exact_lat);
    int lat;
    @(negedge clk);
    s_a = ia; s_b = ib; s_sub = isub; s_start = 1'b1;
    q_sp.push_back({er, ef});
    q_tag_sp.push_back(tag);
    @(negedge clk);
    s_start = 1'b0;
    lat = 1;
    check({tag, "_busy"}, 64'(s_busy), 64'd1);
    while (s_done !== 1'b1 && lat < LIM_SP + 5) begin
      @(negedge clk);
      lat++;
    end
    if (exact_lat != 0) check({tag, "_latency"}, 64'(lat), 64'(exact_lat));
    else                check({tag, "_latency_bound"}, 64'(lat <= LIM_SP), 64'd1);
    @(negedge clk);
    check({tag, "_done_width"}, 64'(s_done), 64'd0);
  endtask

  int base_done;
  int hlat;

  initial begin
    rst = 1'b1;
    s_start = 1'b0; s_sub = 1'b0; s_a = '0; s_b = '0;
    h_start = 1'b0; h_sub = 1'b0; h_a = '0; h_b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",   64'(s_busy),   64'd0);
    check("reset_done",   64'(s_done),   64'd0);
    check("reset_result", 64'(s_result), 64'd0);
    check("reset_flags",  64'(s_flags),  64'd0);
    check("reset_hp_result", 64'(h_result), 64'd0);
    rst = 1'b0;

    run_sp("add_2p5_1p25",  32'h40200000, 32'h3FA00000, 1'b0, 32'h40700000, 4'h0, 0);
    run_sp("sub_3p75_1p25", 32'h40700000, 32'h3FA00000, 1'b1, 32'h40200000, 4'h0, 0);
    run_sp("sub_equal",     32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0, 0);
    run_sp("tie_even",      32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1, 0);
    run_sp("tie_round_up",  32'h3F800000, 32'h34400000, 1'b0, 32'h3F800002, 4'h1, 0);
    run_sp("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5, 0);
    run_sp("inf_sub_inf",   32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'h8, 3);
    run_sp("nan_in",        32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8, 3);
    run_sp("inf_plus_one",  32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'h0, 3);
    run_sp("zero_plus_x",   32'h00000000, 32'hC0000000, 1'b0, 32'hC0000000, 4'h0, 3);
    run_sp("negz_sub_z",    32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'h0, 3);
    run_sp("sub_normalise", 32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 4'h0, 0);
    run_sp("clamp_sticky",  32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 4'h1, 0);
    run_sp("clamp_renorm",  32'h3F800000, 32'h30800000, 1'b1, 32'h3F800000, 4'h1, 0);
    run_sp("underflow",     32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 4'h3, 0);
    run_sp("neg_add",       32'hC0200000, 32'hBFA00000, 1'b0, 32'hC0700000, 4'h0, 0);

    // Reset in the middle of an operation: nothing is queued, so any done is an error.
    @(negedge clk);
    s_a = 32'h40200000; s_b = 32'h3FA00000; s_sub = 1'b0; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    repeat (3) @(negedge clk);
    base_done = n_done_sp;
    rst = 1'b1;
    #30;
    check("midop_rst_busy",   64'(s_busy),   64'd0);
    check("midop_rst_done",   64'(s_done),   64'd0);
    check("midop_rst_result", 64'(s_result), 64'd0);
    check("midop_rst_flags",  64'(s_flags),  64'd0);
    rst = 1'b0;
    repeat (70) @(negedge clk);
    check("midop_no_done", 64'(n_done_sp - base_done), 64'd0);
    run_sp("after_reset", 32'h40200000, 32'h3FA00000, 1'b0, 32'h40700000, 4'h0, 0);

    // Half width, with a start pulsed while busy that must be dropped.
    @(negedge clk);
    h_a = 16'h3C00; h_b = 16'h3C00; h_sub = 1'b0; h_start = 1'b1;
    q_hp.push_back({16'h4000, 4'h0});
    @(negedge clk);
    h_start = 1'b0;
    hlat = 1;
    @(negedge clk);
    hlat++;
    check("hp_busy", 64'(h_busy), 64'd1);
    h_a = 16'h4000; h_b = 16'h4000; h_start = 1'b1;
    @(negedge clk);
    h_start = 1'b0;
    hlat++;
    while (h_done !== 1'b1 && hlat < LIM_HP + 5) begin
      @(negedge clk);
      hlat++;
    end
    check("hp_latency_bound", 64'(hlat <= LIM_HP), 64'd1);
    repeat (40) @(negedge clk);
    check("hp_ignored_result", 64'(h_result), 64'h4000);
    check("hp_ignored_flags",  64'(h_flags),  64'd0);
    check("hp_ignored_busy",   64'(h_busy),   64'd0);

    check("sp_queue_drained", 64'(q_sp.size()), 64'd0);
    check("hp_queue_drained", 64'(q_hp.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
